// File: rtl/lcd_cmd_sequencer.sv
// Fetches a 4-bit opcode program from a synchronous command ROM and hands opcodes one at a
// time to the LCD controller, terminating with opcode 15, guarded by a busy/done watchdog.
module lcd_cmd_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              CROM_rd,
  output logic [ADDR_W-1:0] CROM_A,
  input  logic [3:0]        CROM_Q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              err,
  output logic [ADDR_W:0]   issued
);

  localparam logic [3:0]        OP_NOP    = 4'd14;
  localparam logic [3:0]        OP_END    = 4'd15;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [8:0]        WD_LIMIT  = 9'(TIMEOUT);
  localparam logic [ADDR_W:0]   ISSUED_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, ISSUE, GUARD, RDYW, DONEW, FINISH, ERROR
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              last_reg;
  logic [3:0]        op_reg;
  logic [8:0]        wd_reg;
  logic              crom_rd_reg;
  logic [ADDR_W-1:0] crom_a_reg;
  logic [ADDR_W:0]   issued_reg;

  logic       handover;
  logic       wd_clear;
  logic [8:0] wd_inc;
  logic       wd_trip;
  logic       at_last;

  // The controller samples cmd whenever busy is low, so cmd must be the no-op outside hand-over.
  assign handover  = (state_reg == ISSUE) && !busy;
  assign cmd       = handover ? op_reg : OP_NOP;
  assign cmd_valid = handover;

  assign CROM_rd  = crom_rd_reg;
  assign CROM_A   = crom_a_reg;
  assign issued   = issued_reg;
  assign seq_busy = !((state_reg == IDLE) || (state_reg == FINISH) || (state_reg == ERROR));
  assign seq_done = (state_reg == FINISH);
  assign err      = (state_reg == ERROR);
  assign at_last  = (ptr_reg == LAST_ADDR);

  // While waiting for done, the watchdog times the done wait rather than busy.
  always_comb begin
    wd_clear = 1'b0;
    if ((state_reg == IDLE) || (state_reg == FINISH) || (state_reg == ERROR))
      wd_clear = 1'b1;
    else if (state_reg == DONEW)
      wd_clear = done;
    else
      wd_clear = !busy;
    wd_inc  = wd_reg + 9'd1;
    wd_trip = !wd_clear && (wd_inc == WD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      last_reg    <= 1'b0;
      op_reg      <= OP_NOP;
      wd_reg      <= '0;
      crom_rd_reg <= 1'b0;
      crom_a_reg  <= '0;
      issued_reg  <= '0;
    end else begin
      wd_reg      <= wd_clear ? 9'd0 : wd_inc;
      crom_rd_reg <= 1'b0;
      if (wd_trip) begin
        state_reg <= ERROR;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg   <= FETCH;
              ptr_reg     <= '0;
              last_reg    <= 1'b0;
              issued_reg  <= '0;
              crom_rd_reg <= 1'b1;
              crom_a_reg  <= '0;
            end
          end
          FETCH: state_reg <= LATCH;
          LATCH: begin
            last_reg <= at_last;
            if (!at_last)
              ptr_reg <= ptr_reg + 1'b1;
            if (CROM_Q == OP_NOP) begin
              if (at_last) begin
                op_reg    <= OP_END;
                state_reg <= ISSUE;
              end else begin
                state_reg   <= FETCH;
                crom_rd_reg <= 1'b1;
                crom_a_reg  <= ptr_reg + 1'b1;
              end
            end else begin
              op_reg    <= CROM_Q;
              state_reg <= ISSUE;
            end
          end
          ISSUE: begin
            if (!busy) begin
              if (issued_reg != ISSUED_MAX)
                issued_reg <= issued_reg + 1'b1;
              state_reg <= GUARD;
            end
          end
          GUARD: begin
            if (op_reg == OP_END) begin
              state_reg <= DONEW;
            end else if (last_reg) begin
              op_reg    <= OP_END;
              state_reg <= ISSUE;
            end else begin
              state_reg <= RDYW;
            end
          end
          RDYW: begin
            if (!busy) begin
              state_reg   <= FETCH;
              crom_rd_reg <= 1'b1;
              crom_a_reg  <= ptr_reg;
            end
          end
          DONEW: begin
            if (done)
              state_reg <= FINISH;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench: directed programs push expected opcodes and CROM addresses; monitors pop
// and compare whenever the sequencer hands over an opcode or reads the ROM.
module tb_lcd_cmd_sequencer;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              CROM_rd;
  logic [ADDR_W-1:0] CROM_A;
  logic [3:0]        CROM_Q;
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic              busy;
  logic              done;
  logic              seq_busy;
  logic              seq_done;
  logic              err;
  logic [ADDR_W:0]   issued;

  int tests = 0;
  int fails = 0;

  logic [3:0]        rom [DEPTH];
  logic [3:0]        exp_cmd_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic              force_busy;

  lcd_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start),
    .CROM_rd(CROM_rd), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .seq_busy(seq_busy), .seq_done(seq_done), .err(err), .issued(issued)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address captured with the read enable, data valid the next cycle.
  initial begin
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_a;
    CROM_Q = 4'd14;
    forever begin
      @(negedge clk);
      rom_rd = CROM_rd;
      rom_a  = CROM_A;
      @(posedge clk);
      #1;
      if (rom_rd) CROM_Q = rom[rom_a];
    end
  end

  // Controller: 66-cycle image load after reset, op 0 busy 64 cycles, others 1 cycle,
  // op 15 raises done after 2 busy cycles.
  initial begin
    logic       ctl_acc;
    logic [3:0] ctl_op;
    logic       ctl_rst;
    logic       ctl_fin;
    int         ctl_cnt;
    busy = 1'b1;
    done = 1'b0;
    ctl_cnt = 66;
    ctl_fin = 1'b0;
    forever begin
      @(negedge clk);
      ctl_acc = !busy && (cmd != 4'd14);
      ctl_op  = cmd;
      ctl_rst = rst;
      @(posedge clk);
      #1;
      if (ctl_rst) begin
        ctl_cnt = 66;
        ctl_fin = 1'b0;
        done    = 1'b0;
      end else if (ctl_acc) begin
        ctl_cnt = (ctl_op == 4'd0) ? 64 : ((ctl_op == 4'd15) ? 2 : 1);
        ctl_fin = (ctl_op == 4'd15);
      end else if (ctl_cnt > 0) begin
        ctl_cnt = ctl_cnt - 1;
      end
      if (ctl_fin && ctl_cnt == 0) done = 1'b1;
      busy = force_busy || (ctl_cnt > 0);
    end
  end

  // Monitor: compares every hand-over and every ROM read against the scoreboard queues.
  initial begin
    logic [3:0]        e_cmd;
    logic [ADDR_W-1:0] e_addr;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        tests++;
        if (exp_cmd_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_issue: cmd=%0d issued while none expected", cmd);
        end else begin
          e_cmd = exp_cmd_q.pop_front();
          if (cmd !== e_cmd) begin
            fails++;
            $display("FAIL issue_cmd: got %0d expected %0d", cmd, e_cmd);
          end else begin
            $display("[TB] issue cmd=%0d issued_before=%0d", cmd, issued);
          end
        end
      end else begin
        tests++;
        if (cmd !== 4'd14) begin
          fails++;
          $display("FAIL idle_cmd: got %0d expected 14", cmd);
        end
      end
      if (CROM_rd) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_fetch: CROM_A=%0d while none expected", CROM_A);
        end else begin
          e_addr = exp_addr_q.pop_front();
          if (CROM_A !== e_addr) begin
            fails++;
            $display("FAIL crom_addr: got %0d expected %0d", CROM_A, e_addr);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crom_rd"}, 32'(CROM_rd), 0);
    check({tag, "_crom_a"}, 32'(CROM_A), 0);
    check({tag, "_cmd"}, 32'(cmd), 14);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, "_seq_busy"}, 32'(seq_busy), 0);
    check({tag, "_seq_done"}, 32'(seq_done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_issued"}, 32'(issued), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_rom(input logic [3:0] v);
    for (int i = 0; i < DEPTH; i++) rom[i] = v;
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(ADDR_W'(i));
  endtask

  task automatic wait_end(input string name, input int limit);
    int n;
    n = 0;
    while (!seq_done && !err && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!seq_done && !err) begin
      fails++;
      $display("FAIL %s_timeout: no seq_done/err within %0d cycles", name, limit);
    end
  endtask

  task automatic check_queues(input string name);
    check({name, "_cmd_q_left"}, 32'(exp_cmd_q.size()), 0);
    check({name, "_addr_q_left"}, 32'(exp_addr_q.size()), 0);
    exp_cmd_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    force_busy = 1'b0;
    fill_rom(4'd14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    // Reset while waiting in ISSUE behind the initial image load.
    rom[0] = 4'd1; rom[1] = 4'd5; rom[2] = 4'd0; rom[3] = 4'd15;
    push_addrs(1);
    pulse_start();
    repeat (3) @(negedge clk);
    check("t1_in_issue_seq_busy", 32'(seq_busy), 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t1");
    repeat (10) @(negedge clk);
    check("t1_stays_idle", 32'(seq_busy), 0);
    check_queues("t1");
    $display("[TB] test1 reset mid-ISSUE done");

    // Program 1,5,0,15.
    exp_cmd_q = '{4'd1, 4'd5, 4'd0, 4'd15};
    push_addrs(4);
    pulse_start();
    wait_end("t2", 3000);
    check("t2_seq_done", 32'(seq_done), 1);
    check("t2_done_seen", 32'(done), 1);
    check("t2_err", 32'(err), 0);
    check("t2_issued", 32'(issued), 4);
    repeat (5) @(negedge clk);
    check("t2_seq_done_sticky", 32'(seq_done), 1);
    check_queues("t2");
    $display("[TB] test2 program 1,5,0,15 issued=%0d", issued);

    // Reserved 14 entries are skipped.
    do_reset();
    fill_rom(4'd14);
    rom[2] = 4'd7; rom[3] = 4'd15;
    exp_cmd_q = '{4'd7, 4'd15};
    push_addrs(4);
    pulse_start();
    wait_end("t3", 3000);
    check("t3_seq_done", 32'(seq_done), 1);
    check("t3_issued", 32'(issued), 2);
    check_queues("t3");
    $display("[TB] test3 skip-14 program issued=%0d", issued);

    // Full ROM of 8 with no terminator: auto-issued 15 after the last entry.
    do_reset();
    fill_rom(4'd8);
    for (int i = 0; i < DEPTH; i++) exp_cmd_q.push_back(4'd8);
    exp_cmd_q.push_back(4'd15);
    push_addrs(DEPTH);
    pulse_start();
    wait_end("t4", 5000);
    check("t4_seq_done", 32'(seq_done), 1);
    check("t4_issued", 32'(issued), 65);
    check_queues("t4");
    $display("[TB] test4 full ROM auto-terminate issued=%0d", issued);

    // Start pulses in RDYW and FINISH must be ignored.
    do_reset();
    fill_rom(4'd14);
    rom[0] = 4'd1; rom[1] = 4'd0; rom[2] = 4'd15;
    exp_cmd_q = '{4'd1, 4'd0, 4'd15};
    push_addrs(3);
    pulse_start();
    n = 0;
    while (!(cmd_valid && cmd == 4'd0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_op0", 32'(n < 2000), 1);
    repeat (5) @(negedge clk);
    check("t6_in_rdyw_busy", 32'(seq_busy), 1);
    pulse_start();
    wait_end("t6", 3000);
    check("t6_seq_done", 32'(seq_done), 1);
    pulse_start();
    repeat (20) @(negedge clk);
    check("t6_finish_sticky", 32'(seq_done), 1);
    check("t6_issued", 32'(issued), 3);
    check_queues("t6");
    $display("[TB] test6 ignored start pulses issued=%0d", issued);

    // Busy stuck high: watchdog trips 255 cycles after start.
    force_busy = 1'b1;
    do_reset();
    fill_rom(4'd14);
    rom[0] = 4'd1; rom[1] = 4'd15;
    push_addrs(1);
    pulse_start();
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t5_trip_cycles", 32'(n), 255);
    check("t5_err", 32'(err), 1);
    check("t5_cmd", 32'(cmd), 14);
    check("t5_cmd_valid", 32'(cmd_valid), 0);
    check("t5_seq_busy", 32'(seq_busy), 0);
    check("t5_seq_done", 32'(seq_done), 0);
    check("t5_issued", 32'(issued), 0);
    force_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_err_sticky", 32'(err), 1);
    check_queues("t5");
    $display("[TB] test5 watchdog err=%0d after %0d cycles", err, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
